ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single data RAM between the CPU_RV32I data port (master 0) and a DMA/program-loader master (master 1).
- Sits between the masters and RAM, replacing the direct CPU-to-RAM bus wiring in MCU.
- Round-robin arbitration with optional locked bursts, bounded by MAX_BURST so neither master starves.
- One access (beat) per granted cycle. The RAM read path is combinational.

Parameters:
- MAX_BURST, 8: maximum consecutive locked beats one master may hold before forced re-arbitration. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 access request; held with its fields until m0_rdy
- m0_lock  in  1  master 0 requests to keep the grant after this beat
- m0_we  in  1  master 0 write enable
- m0_addr  in  32  master 0 byte address
- m0_wData  in  32  master 0 write data
- m0_func3  in  3  master 0 access size/sign (RV32I load/store func3)
- m0_rdy  out  1  master 0 beat completes this cycle
- m0_rData  out  32  master 0 read data, valid when m0_rdy=1
- m1_req, m1_lock, m1_we, m1_addr, m1_wData, m1_func3, m1_rdy, m1_rData: same as master 0, for master 1
- busWe  out  1  RAM write enable
- busAddr  out  32  RAM address
- busWData  out  32  RAM write data
- busFunc3  out  3  RAM func3
- busRData  in  32  RAM read data (combinational)
- owner  out  2  debug: 00 idle, 01 master 0, 10 master 1

Behaviour:
- State register: IDLE, GNT0, GNT1. Also a last-owner pointer lastM (1 bit) and a beat counter beatCnt (8 bits).
- Reset (reset=0, async):
  - state=IDLE, lastM=1 (master 0 wins the first tie), beatCnt=0.
  - All outputs are decoded from state and are therefore 0: busWe, busAddr, busWData, busFunc3, m0_rdy, m1_rdy, owner.
- IDLE:
  - No bus access; bus outputs are 0; no rdy.
  - Next state: only m0_req -> GNT0; only m1_req -> GNT1.
  - Both requesting -> grant the master that is not lastM.
  - Neither requesting -> stay IDLE.
- GNTx with mx_req=1 (a beat):
  - Bus outputs pass mx_we/addr/wData/func3 through.
  - mx_rdy=1 and mx_rData=busRData, both combinational.
  - A write commits to RAM at the closing clock edge.
  - At the edge: lastM<=x, beatCnt<=beatCnt+1.
- GNTx with mx_req=0:
  - No access, rdy stays 0, next state IDLE, beatCnt<=0.
  - This covers a master dropping the lock without a further request.
- Next state after a beat:
  - If mx_lock=1 and beatCnt+1 < MAX_BURST: stay GNTx.
  - Else if the other master is requesting: go to GNT(other) with beatCnt<=0.
  - Else: IDLE with beatCnt<=0.
  - When the burst limit is reached and the other master is idle, the next state is IDLE, not a re-grant.
- Latency and throughput:
  - From IDLE: req at cycle N -> rdy at cycle N+1.
  - A locked burst gives one beat per cycle.
  - Unlocked single accesses from one master complete every 2 cycles.
  - Alternating masters with both requesting complete one beat per cycle (ping-pong).
- The non-owner's rdy is always 0; its rData is 0.
- Non-owner input changes have no effect on the bus.
- Simultaneous events:
  - A request from the non-owner during a locked burst waits.
  - It waits at most MAX_BURST beats, plus one cycle if the owner idles.
- Reset asserted mid-burst: immediate return to IDLE with all outputs 0. Any write in the interrupted cycle is not committed because busWe drops asynchronously.
- No combinational path from busRData to any bus output. rdy does not depend on req of the other master.

Test Plan:
- Single read: m0_req=1, we=0, addr=0x10, func3=3'b010, RAM[0x10]=0xDEADBEEF -> m0_rdy=1 exactly one cycle later, m0_rData=0xDEADBEEF; owner=01 then 00.
- Tie and round-robin:
  - Both req asserted in the same cycle after reset -> master 0 is served first, master 1 on the next cycle.
  - A second tie -> master 0 again, because lastM is now 1.
- Lock limit:
  - Setup: m1_lock=1 and m1_req held for 20 cycles with MAX_BURST=8, m0_req=1 throughout.
  - Required: exactly 8 consecutive m1_rdy pulses, then one m0 beat, then m1 resumes.
- Write isolation:
  - Setup: m0 writes 0x12345678 to 0x20 while m1 presents we=1 to 0x20 with 0xFFFFFFFF without a grant.
  - Required: a read of 0x20 returns 0x12345678.
- Reset mid-burst: reset=0 during the third beat of a locked m1 burst -> busWe=0, rdy=0, owner=00 within the same cycle; after release, both req -> master 0 wins.
- Lock with request dropped: m0_lock=1, m0_req falls after beat 1 -> one idle GNT0 cycle with no rdy, then IDLE, beatCnt=0.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master round-robin arbiter in front of the single data RAM.
// Master 0 is the CPU data port and master 1 is the DMA/program loader.
// One beat per granted cycle. A master may lock the grant for up to MAX_BURST
// consecutive beats, after which the other master is served if it is waiting.
// Bus outputs and rdy are decoded from the grant state and the owner's request.
// The RAM read path is combinational.
module ram_bus_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wData,
  input  logic [2:0]  m0_func3,
  output logic        m0_rdy,
  output logic [31:0] m0_rData,

  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wData,
  input  logic [2:0]  m1_func3,
  output logic        m1_rdy,
  output logic [31:0] m1_rData,

  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [2:0]  busFunc3,
  input  logic [31:0] busRData,

  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);

  state_t     state_q, state_d;
  logic       last_m_q, last_m_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic       beat0;
  logic       beat1;
  logic [8:0] beat_next;

  // A beat happens only when the current owner is actually requesting.
  assign beat0     = (state_q == GNT0) && m0_req;
  assign beat1     = (state_q == GNT1) && m1_req;
  assign beat_next = {1'b0, beat_cnt_q} + 9'd1;

  // Grant sequencing: round-robin on ties, locked bursts bounded by MAX_BURST.
  always_comb begin
    state_d    = state_q;
    last_m_d   = last_m_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (m0_req && m1_req) begin
          state_d = last_m_q ? GNT0 : GNT1;
        end else if (m0_req) begin
          state_d = GNT0;
        end else if (m1_req) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (m0_req) begin
          last_m_d = 1'b0;
          if (m0_lock && (beat_next < MAX_BURST_W)) begin
            state_d    = GNT0;
            beat_cnt_d = beat_next[7:0];
          end else begin
            beat_cnt_d = '0;
            state_d    = m1_req ? GNT1 : IDLE;
          end
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      GNT1: begin
        if (m1_req) begin
          last_m_d = 1'b1;
          if (m1_lock && (beat_next < MAX_BURST_W)) begin
            state_d    = GNT1;
            beat_cnt_d = beat_next[7:0];
          end else begin
            beat_cnt_d = '0;
            state_d    = m0_req ? GNT0 : IDLE;
          end
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State, last-owner pointer and burst counter; lastM=1 lets master 0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_m_q   <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_m_q   <= last_m_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Bus mux and per-master handshake; everything is zero unless a beat is in progress.
  always_comb begin
    busWe    = 1'b0;
    busAddr  = '0;
    busWData = '0;
    busFunc3 = '0;
    m0_rdy   = 1'b0;
    m1_rdy   = 1'b0;
    m0_rData = '0;
    m1_rData = '0;
    if (beat0) begin
      busWe    = m0_we;
      busAddr  = m0_addr;
      busWData = m0_wData;
      busFunc3 = m0_func3;
      m0_rdy   = 1'b1;
      m0_rData = busRData;
    end else if (beat1) begin
      busWe    = m1_we;
      busAddr  = m1_addr;
      busWData = m1_wData;
      busFunc3 = m1_func3;
      m1_rdy   = 1'b1;
      m1_rData = busRData;
    end
  end

  // Debug owner code follows the grant state alone.
  always_comb begin
    unique case (state_q)
      GNT0:    owner = 2'b01;
      GNT1:    owner = 2'b10;
      default: owner = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: scoreboard bench for ram_bus_arbiter.
// The bench plays the RAM, predicts each cycle from the arbitration rules and
// checks the DUT outputs on the falling edge.
module tb_ram_bus_arbiter;

  localparam int MAX_BURST = 8;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } mreq_t;

  typedef struct packed {
    logic        rdy0;
    logic        rdy1;
    logic [1:0]  owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_lock, m0_we, m0_rdy;
  logic [31:0] m0_addr, m0_wData, m0_rData;
  logic [2:0]  m0_func3;
  logic        m1_req, m1_lock, m1_we, m1_rdy;
  logic [31:0] m1_addr, m1_wData, m1_rData;
  logic [2:0]  m1_func3;
  logic        busWe;
  logic [31:0] busAddr, busWData, busRData;
  logic [2:0]  busFunc3;
  logic [1:0]  owner;

  logic [31:0] ram       [0:255];
  logic [31:0] model_mem [0:255];
  exp_t        exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_holder = -1;
  int mdl_burst  = 0;
  int mdl_prefer = 0;

  ram_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wData(m0_wData), .m0_func3(m0_func3), .m0_rdy(m0_rdy), .m0_rData(m0_rData),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wData(m1_wData), .m1_func3(m1_func3), .m1_rdy(m1_rdy), .m1_rData(m1_rData),
    .busWe(busWe), .busAddr(busAddr), .busWData(busWData), .busFunc3(busFunc3),
    .busRData(busRData), .owner(owner)
  );

  always #5 clk = ~clk;

  // Word-addressed RAM with combinational read and write at the rising edge.
  assign busRData = ram[busAddr[9:2]];
  always @(posedge clk) begin
    if (busWe) ram[busAddr[9:2]] <= busWData;
  end

  function automatic mreq_t mk(input logic req, input logic lock, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] func3);
    mreq_t m;
    m.req = req; m.lock = lock; m.we = we;
    m.addr = addr; m.wdata = wdata; m.func3 = func3;
    return m;
  endfunction

  function automatic mreq_t rand_master(input int req_pct, input int lock_pct);
    mreq_t m;
    m.req   = ($urandom_range(0, 99) < req_pct);
    m.lock  = ($urandom_range(0, 99) < lock_pct);
    m.we    = 1'($urandom_range(0, 1));
    m.addr  = 32'($urandom_range(0, 255)) << 2;
    m.wdata = $urandom;
    m.func3 = 3'($urandom_range(0, 7));
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  task automatic check_output(input exp_t e);
    chk("owner",    32'(owner),    32'(e.owner));
    chk("m0_rdy",   32'(m0_rdy),   32'(e.rdy0));
    chk("m1_rdy",   32'(m1_rdy),   32'(e.rdy1));
    chk("busWe",    32'(busWe),    32'(e.we));
    chk("busAddr",  busAddr,       e.addr);
    chk("busWData", busWData,      e.wdata);
    chk("busFunc3", 32'(busFunc3), 32'(e.func3));
    chk("m0_rData", m0_rData,      e.rd0);
    chk("m1_rData", m1_rData,      e.rd1);
  endtask

  // Drive one cycle of inputs and predict what the DUT must show during it.
  task automatic apply_stimulus(input mreq_t a, input mreq_t b, input logic rst_in,
                                output logic srv0, output logic srv1);
    exp_t  e;
    mreq_t cur, oth;
    int    idx;
    @(posedge clk);
    #1;
    reset    = rst_in;
    m0_req   = a.req;  m0_lock = a.lock; m0_we = a.we;
    m0_addr  = a.addr; m0_wData = a.wdata; m0_func3 = a.func3;
    m1_req   = b.req;  m1_lock = b.lock; m1_we = b.we;
    m1_addr  = b.addr; m1_wData = b.wdata; m1_func3 = b.func3;
    e = '0;
    srv0 = 1'b0;
    srv1 = 1'b0;
    if (!rst_in) begin
      mdl_holder = -1;
      mdl_burst  = 0;
      mdl_prefer = 0;
    end else if (mdl_holder < 0) begin
      if (a.req && b.req)  mdl_holder = mdl_prefer;
      else if (a.req)      mdl_holder = 0;
      else if (b.req)      mdl_holder = 1;
    end else begin
      cur = (mdl_holder == 0) ? a : b;
      oth = (mdl_holder == 0) ? b : a;
      e.owner = (mdl_holder == 0) ? 2'b01 : 2'b10;
      if (cur.req) begin
        idx     = int'(cur.addr[9:2]);
        e.we    = cur.we;
        e.addr  = cur.addr;
        e.wdata = cur.wdata;
        e.func3 = cur.func3;
        if (mdl_holder == 0) begin
          e.rdy0 = 1'b1; e.rd0 = model_mem[idx]; srv0 = 1'b1;
        end else begin
          e.rdy1 = 1'b1; e.rd1 = model_mem[idx]; srv1 = 1'b1;
        end
        if (cur.we) model_mem[idx] = cur.wdata;
        mdl_prefer = 1 - mdl_holder;
        mdl_burst++;
        if (!(cur.lock && mdl_burst < MAX_BURST)) begin
          mdl_burst  = 0;
          mdl_holder = oth.req ? 1 - mdl_holder : -1;
        end
      end else begin
        mdl_holder = -1;
        mdl_burst  = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mreq_t idle, a, b, w1, ra, rb;
    logic  s0, s1;

    reset = 1'b0;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wData = 0; m0_func3 = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wData = 0; m1_func3 = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]       = $urandom;
      model_mem[i] = ram[i];
    end
    ram[4]       = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;
    idle = '0;

    // Reset state.
    apply_stimulus(idle, idle, 1'b0, s0, s1);
    apply_stimulus(idle, idle, 1'b0, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    // Single read of 0x10.
    a = mk(1, 0, 0, 32'h10, 32'h0, 3'b010);
    apply_stimulus(a, idle, 1'b1, s0, s1);
    apply_stimulus(a, idle, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    // Two ties in a row: master 0 first both times.
    a = mk(1, 0, 0, 32'h44, 32'h0, 3'b010);
    b = mk(1, 0, 0, 32'h88, 32'h0, 3'b001);
    for (int t = 0; t < 2; t++) begin
      apply_stimulus(a, b, 1'b1, s0, s1);
      apply_stimulus(a, b, 1'b1, s0, s1);
      apply_stimulus(idle, b, 1'b1, s0, s1);
      apply_stimulus(idle, idle, 1'b1, s0, s1);
    end

    // Locked m1 burst against a persistent m0 request.
    a = mk(1, 0, 0, 32'h100, 32'h0, 3'b010);
    b = mk(1, 1, 0, 32'h200, 32'h0, 3'b010);
    apply_stimulus(idle, b, 1'b1, s0, s1);
    for (int i = 0; i < 20; i++) apply_stimulus(a, b, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    // Write isolation: un-granted m1 write to 0x20 must not land.
    a  = mk(1, 0, 1, 32'h20, 32'h12345678, 3'b010);
    w1 = mk(0, 0, 1, 32'h20, 32'hFFFFFFFF, 3'b010);
    apply_stimulus(a, w1, 1'b1, s0, s1);
    apply_stimulus(a, w1, 1'b1, s0, s1);
    apply_stimulus(idle, w1, 1'b1, s0, s1);
    a = mk(1, 0, 0, 32'h20, 32'h0, 3'b010);
    apply_stimulus(a, w1, 1'b1, s0, s1);
    apply_stimulus(a, w1, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    // Reset during the third beat of a locked m1 write burst.
    b = mk(1, 1, 1, 32'h40, 32'hAAAA0001, 3'b010);
    apply_stimulus(idle, b, 1'b1, s0, s1);
    apply_stimulus(idle, b, 1'b1, s0, s1);
    b.wdata = 32'hAAAA0002;
    apply_stimulus(idle, b, 1'b1, s0, s1);
    b.wdata = 32'hBBBB0003;
    apply_stimulus(idle, b, 1'b0, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);
    a = mk(1, 0, 0, 32'h40, 32'h0, 3'b010);
    b = mk(1, 0, 0, 32'h40, 32'h0, 3'b010);
    apply_stimulus(a, b, 1'b1, s0, s1);
    apply_stimulus(a, b, 1'b1, s0, s1);
    apply_stimulus(idle, b, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    // Locked m0 drops its request after one beat.
    a = mk(1, 1, 0, 32'h60, 32'h0, 3'b010);
    apply_stimulus(a, idle, 1'b1, s0, s1);
    apply_stimulus(a, idle, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    // Randomized traffic; requests hold their fields until served.
    ra = idle; rb = idle; s0 = 1'b1; s1 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      logic rst_in;
      if (!ra.req || s0) ra = rand_master(55, 40);
      if (!rb.req || s1) rb = rand_master(55, 70);
      rst_in = ($urandom_range(0, 149) != 0);
      apply_stimulus(ra, rb, rst_in, s0, s1);
    end
    apply_stimulus(idle, idle, 1'b1, s0, s1);
    apply_stimulus(idle, idle, 1'b1, s0, s1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
